// File: rtl/tomasulo_cdb_sch.sv
// CDB writeback scheduler: round-robin grant among reservation stations, gated by
// a slot-reservation shift vector so that no two results ever land on the CDB together.
module tomasulo_cdb_sch #(
  parameter int N     = 3,
  parameter int LAT_W = 3,
  parameter int SCH_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*LAT_W-1:0]   lat,
  output logic [N-1:0]         gnt,
  output logic [SCH_W-1:0]     sch_r,
  output logic                 cdb_vld,
  output logic [$clog2(N)-1:0] cdb_own
);

  localparam int OWN_W = $clog2(N);

  logic [LAT_W-1:0] lat_a    [N];
  logic [OWN_W-1:0] own      [SCH_W];
  logic [OWN_W-1:0] own_next [SCH_W];
  logic [OWN_W-1:0] rr_ptr, rr_next, win;
  logic [LAT_W-1:0] win_lat;
  logic [SCH_W-1:0] sch_next;
  logic [N-1:0]     legal, busy, elig;
  logic             found;
  int               idx;

  // A requester is eligible only if its latency is legal and its landing slot is still free.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lat_a[i] = lat[i*LAT_W +: LAT_W];
      legal[i] = (int'(lat_a[i]) + 1) <= (SCH_W - 1);
      busy[i]  = 1'b0;
      for (int k = 0; k < SCH_W; k++) begin
        if (k == int'(lat_a[i]) + 1) busy[i] = sch_r[k];
      end
      elig[i] = req[i] & legal[i] & ~busy[i];
    end
  end

  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_lat = '0;
    idx     = 0;
    for (int j = 0; j < N; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        win     = OWN_W'(idx);
        win_lat = lat_a[idx];
      end
    end
    gnt = found ? (N'(1) << win) : '0;
    rr_next = rr_ptr;
    if (found) rr_next = (int'(win) == N - 1) ? '0 : win + OWN_W'(1);
  end

  // Grant at t with latency L lands at t+L+1, i.e. bit L of the already-shifted vector.
  always_comb begin
    sch_next = sch_r >> 1;
    for (int k = 0; k < SCH_W - 1; k++) own_next[k] = own[k+1];
    own_next[SCH_W-1] = '0;
    for (int k = 0; k < SCH_W; k++) begin
      if (found && k == int'(win_lat)) begin
        sch_next[k] = 1'b1;
        own_next[k] = win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sch_r  <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < SCH_W; k++) own[k] <= '0;
    end else begin
      sch_r  <= sch_next;
      rr_ptr <= rr_next;
      for (int k = 0; k < SCH_W; k++) own[k] <= own_next[k];
    end
  end

  assign cdb_vld = sch_r[0];
  assign cdb_own = sch_r[0] ? own[0] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt)) else $error("gnt not one-hot");
      assert ((gnt & ~req) == '0) else $error("gnt not subset of req");
      for (int i = 0; i < N; i++) begin
        if (req[i]) assert (legal[i]) else $error("illegal latency on requester %0d", i);
      end
      for (int k = 0; k < SCH_W; k++) begin
        if (found && k == int'(win_lat) + 1) assert (!sch_r[k]) else $error("granted slot already set");
      end
    end
  end

endmodule
